// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg: shared state encoding and default widths for the A-to-B APB bridge
package apb_bridge_pkg;
   localparam int ADDR_WD_DEF = 32;
   localparam int DATA_WD_DEF = 32;
   localparam int STRB_WD_DEF = 4;
   localparam int PROT_WD_DEF = 3;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;
endpackage

// File: rtl/apb_toggle_sync.sv
// apb_toggle_sync: three-flop synchronizer turning each toggle of in into a one-cycle pulse
module apb_toggle_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   output logic pulse
);
   logic s1, s2, s3;
   // shift the asynchronous toggle through the synchronizer chain
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {s1, s2, s3} <= 3'b000;
      else {s1, s2, s3} <= {in, s1, s2};
   assign pulse = s2 ^ s3;
endmodule

// File: rtl/low_frequency_apb.sv
// low_frequency_apb: toggle-handshake request from the A domain executed as an APB master transfer
module low_frequency_apb
   import apb_bridge_pkg::*;
#(
   parameter int ADDR_WD = ADDR_WD_DEF,
   parameter int DATA_WD = DATA_WD_DEF,
   parameter int STRB_WD = STRB_WD_DEF,
   parameter int PROT_WD = PROT_WD_DEF
) (
   input  logic               b_pclk,
   input  logic               b_prst_n,
   input  logic               a_apb_req,
   input  logic               write,
   input  logic [ADDR_WD-1:0] addr,
   input  logic [DATA_WD-1:0] wdata,
   input  logic [PROT_WD-1:0] prot,
   input  logic [STRB_WD-1:0] strb,
   output logic               b_ready_req,
   output logic [DATA_WD-1:0] rdata,
   output logic               b_psel,
   output logic               b_penable,
   output logic               b_pwrite,
   output logic [ADDR_WD-1:0] b_paddr,
   output logic [DATA_WD-1:0] b_pwdata,
   output logic [PROT_WD-1:0] b_pprot,
   output logic [STRB_WD-1:0] b_pstrb,
   input  logic [DATA_WD-1:0] b_prdata,
   input  logic               b_pready
);
   apb_state_t state, state_n;
   logic req_ev, pending, start, done;

   apb_toggle_sync u_sync (
      .clk  (b_pclk),
      .rst_n(b_prst_n),
      .in   (a_apb_req),
      .pulse(req_ev)
   );

   // state register
   always_ff @(posedge b_pclk or negedge b_prst_n)
      if (!b_prst_n) state <= IDLE;
      else state <= state_n;

   // next state and APB control decode
   always_comb begin
      state_n   = state;
      b_psel    = 1'b0;
      b_penable = 1'b0;
      start     = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            start = req_ev | pending;
            if (start) state_n = SETUP;
         end
         SETUP: begin
            b_psel  = 1'b1;
            state_n = ACCESS;
         end
         ACCESS: begin
            b_psel    = 1'b1;
            b_penable = 1'b1;
            done      = b_pready;
            if (b_pready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // payload capture, pending request, completion toggle and read data return
   always_ff @(posedge b_pclk or negedge b_prst_n)
      if (!b_prst_n) begin
         pending     <= 1'b0;
         b_ready_req <= 1'b0;
         rdata       <= '0;
         b_pwrite    <= 1'b0;
         b_paddr     <= '0;
         b_pwdata    <= '0;
         b_pprot     <= '0;
         b_pstrb     <= '0;
      end else begin
         pending <= start ? 1'b0 : (b_psel && req_ev) ? 1'b1 : pending;
         if (start) begin
            b_pwrite <= write;
            b_paddr  <= addr;
            b_pwdata <= wdata;
            b_pprot  <= prot;
            b_pstrb  <= strb;
         end
         if (done) begin
            b_ready_req <= ~b_ready_req;
            if (!b_pwrite) rdata <= b_prdata;
         end
      end
endmodule

// File: tb/tb_low_frequency_apb.sv
// tb_low_frequency_apb: directed checks of the toggle-request APB bridge
module tb_low_frequency_apb;
   logic        b_pclk = 1'b0;
   logic        b_prst_n = 1'b0;
   logic        a_apb_req = 1'b0;
   logic        write = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [2:0]  prot = '0;
   logic [3:0]  strb = '0;
   logic        b_ready_req;
   logic [31:0] rdata;
   logic        b_psel, b_penable, b_pwrite;
   logic [31:0] b_paddr, b_pwdata;
   logic [2:0]  b_pprot;
   logic [3:0]  b_pstrb;
   logic [31:0] b_prdata = '0;
   logic        b_pready = 1'b0;

   int tests = 0;
   int fails = 0;
   logic        seen, stable, w, rr_exp;
   logic [31:0] a, d, rd_exp;
   int          n;

   low_frequency_apb dut (
      .b_pclk     (b_pclk),
      .b_prst_n   (b_prst_n),
      .a_apb_req  (a_apb_req),
      .write      (write),
      .addr       (addr),
      .wdata      (wdata),
      .prot       (prot),
      .strb       (strb),
      .b_ready_req(b_ready_req),
      .rdata      (rdata),
      .b_psel     (b_psel),
      .b_penable  (b_penable),
      .b_pwrite   (b_pwrite),
      .b_paddr    (b_paddr),
      .b_pwdata   (b_pwdata),
      .b_pprot    (b_pprot),
      .b_pstrb    (b_pstrb),
      .b_prdata   (b_prdata),
      .b_pready   (b_pready)
   );

   always #5 b_pclk = ~b_pclk;

   task automatic step(input int cycles);
      repeat (cycles) @(negedge b_pclk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      // reset and quiet idle period
      step(2);
      b_prst_n = 1'b1;
      chk("rst_psel", 32'(b_psel), 0);
      chk("rst_penable", 32'(b_penable), 0);
      chk("rst_paddr", b_paddr, 0);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         seen |= b_psel;
      end
      chk("idle_no_psel", 32'(seen), 0);
      chk("idle_ready_req", 32'(b_ready_req), 0);
      chk("idle_rdata", rdata, 0);

      // zero-wait write
      write = 1'b1; addr = 32'h1000_0004; wdata = 32'hDEAD_BEEF; strb = 4'hF; prot = 3'h2;
      b_pready = 1'b1; a_apb_req = 1'b1;
      step(2);
      chk("wr_latency", 32'(b_psel), 0);
      step(1);
      chk("wr_setup", 32'({b_penable, b_psel}), 1);
      chk("wr_paddr", b_paddr, 32'h1000_0004);
      chk("wr_pwdata", b_pwdata, 32'hDEAD_BEEF);
      chk("wr_pwrite", 32'(b_pwrite), 1);
      chk("wr_pstrb", 32'(b_pstrb), 32'hF);
      chk("wr_pprot", 32'(b_pprot), 2);
      addr = 32'hFFFF_0000; wdata = 32'h0;
      step(1);
      chk("wr_access", 32'({b_penable, b_psel}), 3);
      chk("wr_paddr_stable", b_paddr, 32'h1000_0004);
      chk("wr_pwdata_stable", b_pwdata, 32'hDEAD_BEEF);
      chk("wr_rr_before", 32'(b_ready_req), 0);
      step(1);
      chk("wr_idle", 32'({b_penable, b_psel}), 0);
      chk("wr_rr_after", 32'(b_ready_req), 1);
      chk("wr_rdata_hold", rdata, 0);
      chk("wr_paddr_hold", b_paddr, 32'h1000_0004);

      // read with three wait states
      write = 1'b0; addr = 32'h20; b_pready = 1'b0; b_prdata = 32'h1234_5678; a_apb_req = 1'b0;
      step(3);
      chk("rd_setup", 32'({b_penable, b_psel}), 1);
      chk("rd_paddr", b_paddr, 32'h20);
      chk("rd_pwrite", 32'(b_pwrite), 0);
      step(1);
      chk("rd_access1", 32'({b_penable, b_psel}), 3);
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("rd_wait", 32'({b_penable, b_psel}), 3);
      end
      chk("rd_rr_before", 32'(b_ready_req), 1);
      chk("rd_rdata_before", rdata, 0);
      b_pready = 1'b1;
      step(1);
      chk("rd_idle", 32'(b_psel), 0);
      chk("rd_rdata", rdata, 32'h1234_5678);
      chk("rd_rr_after", 32'(b_ready_req), 0);

      // second request arriving during ACCESS
      write = 1'b1; addr = 32'h40; wdata = 32'hA5A5_A5A5; b_pready = 1'b0; a_apb_req = 1'b1;
      step(4);
      addr = 32'h44; wdata = 32'h5A5A_5A5A; a_apb_req = 1'b0;
      step(3);
      chk("b2b_hold", 32'({b_penable, b_psel}), 3);
      chk("b2b_paddr1", b_paddr, 32'h40);
      b_pready = 1'b1;
      step(1);
      chk("b2b_gap", 32'(b_psel), 0);
      chk("b2b_rr1", 32'(b_ready_req), 1);
      step(1);
      chk("b2b_setup2", 32'({b_penable, b_psel}), 1);
      chk("b2b_paddr2", b_paddr, 32'h44);
      chk("b2b_pwdata2", b_pwdata, 32'h5A5A_5A5A);
      step(2);
      chk("b2b_done2", 32'(b_psel), 0);
      chk("b2b_rr2", 32'(b_ready_req), 0);
      chk("b2b_rdata_hold", rdata, 32'h1234_5678);

      // reset during a stalled ACCESS
      write = 1'b0; addr = 32'h80; b_pready = 1'b0; b_prdata = 32'hCAFE_F00D; a_apb_req = 1'b1;
      step(4);
      chk("rst_mid_access", 32'({b_penable, b_psel}), 3);
      #2 b_prst_n = 1'b0;
      #1 chk("rst_mid_drop", 32'({b_penable, b_psel}), 0);
      chk("rst_mid_rr", 32'(b_ready_req), 0);
      chk("rst_mid_rdata", rdata, 0);
      a_apb_req = 1'b0;
      step(2);
      b_prst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         seen |= b_psel;
      end
      chk("rst_exit_quiet", 32'(seen), 0);
      chk("rst_exit_rr", 32'(b_ready_req), 0);
      write = 1'b1; addr = 32'hC0; wdata = 32'h1122_3344; b_pready = 1'b1; a_apb_req = 1'b1;
      step(3);
      chk("post_rst_setup", 32'({b_penable, b_psel}), 1);
      chk("post_rst_paddr", b_paddr, 32'hC0);
      step(2);
      chk("post_rst_done", 32'(b_psel), 0);
      chk("post_rst_rr", 32'(b_ready_req), 1);

      // random payloads, wait states and request spacing
      rr_exp = 1'b1;
      rd_exp = 32'h0;
      for (int k = 0; k < 20; k++) begin
         a = $urandom; d = $urandom; w = 1'($urandom_range(0, 1));
         addr = a; wdata = d; write = w; b_prdata = ~d; b_pready = 1'b0;
         a_apb_req = ~a_apb_req;
         rr_exp = ~rr_exp;
         n = 0;
         while (!b_psel && n < 10) begin
            step(1);
            n++;
         end
         chk("rnd_setup", 32'({b_penable, b_psel}), 1);
         chk("rnd_paddr", b_paddr, a);
         stable = 1'b1;
         n = 0;
         while (b_psel && n < 20) begin
            b_pready = (n > 4) ? 1'b1 : 1'($urandom_range(0, 1));
            step(1);
            n++;
            if (b_psel) stable &= (b_paddr == a) && (b_pwdata == d) && (b_pwrite == w);
         end
         if (!w) rd_exp = ~d;
         chk("rnd_stable", 32'(stable), 1);
         chk("rnd_done", 32'(b_psel), 0);
         chk("rnd_rr", 32'(b_ready_req), 32'(rr_exp));
         chk("rnd_rdata", rdata, rd_exp);
         step($urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
